// File: rtl/mdu_iterative.sv
// mdu_iterative: HI/LO multiply/divide unit, shift-add multiply and restoring divide, one bit per cycle
module mdu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiWe,
  input  logic             LoWe,
  input  logic [WIDTH-1:0] WD,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2;
  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               div, sa, sb, bz;
  logic [WIDTH-1:0]   mb;
  logic [2*WIDTH-1:0] acc, nxt, prod;
  logic [WIDTH:0]     sum, dif;
  logic               sa_in, sb_in;
  logic [WIDTH-1:0]   ma_in, mb_in, quo, rem;
  // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    sa_in = Op[0] & A[WIDTH-1];
    sb_in = Op[0] & B[WIDTH-1];
    ma_in = sa_in ? -A : A;
    mb_in = sb_in ? -B : B;
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mb : {WIDTH{1'b0}})};
    dif   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mb};
    nxt   = !div ? {sum, acc[WIDTH-1:1]} :
            dif[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {dif[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    prod  = (sa ^ sb) ? -acc : acc;
    quo   = bz ? {WIDTH{1'b1}} : (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem   = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= '0;
      div   <= 1'b0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      bz    <= 1'b0;
      mb    <= '0;
      acc   <= '0;
      HI    <= '0;
      LO    <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: if (Start) begin
          state <= CALC;
          Busy  <= 1'b1;
          cnt   <= '0;
          div   <= Op[1];
          sa    <= sa_in;
          sb    <= sb_in;
          bz    <= Op[1] && B == '0;
          mb    <= mb_in;
          acc   <= {{WIDTH{1'b0}}, ma_in};
        end else begin
          if (HiWe) HI <= WD;
          if (LoWe) LO <= WD;
        end
        CALC: begin
          acc <= nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b1;
          HI    <= div ? rem : prod[2*WIDTH-1:WIDTH];
          LO    <= div ? quo : prod[WIDTH-1:0];
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Multi-cycle multiply/divide unit (HI/LO) for the MIPS datapath.
- Sits directly downstream of the register file: operands come from RDA/RDB, and HI/LO results return to the register-file write-data path (MFHI/MFLO).
- Shift-add multiply and restoring divide, one bit per cycle.
- Exposes a Busy/Done handshake so the controller stalls while the unit is busy.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits. Iteration count = WIDTH.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- Start  input  1  request a new operation; sampled only in IDLE.
- Op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- A  input  WIDTH  operand A (rs / dividend).
- B  input  WIDTH  operand B (rt / divisor).
- HiWe  input  1  MTHI write enable.
- LoWe  input  1  MTLO write enable.
- WD  input  WIDTH  MTHI/MTLO data.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- HI  output  WIDTH  HI register (product high word / remainder).
- LO  output  WIDTH  LO register (product low word / quotient).

Behaviour:
- Reset (Reset=0, asynchronous):
  - State = IDLE.
  - HI, LO, Busy, Done, counter and all internal datapath registers = 0.
  - Applies immediately, including mid-operation; the in-flight result is discarded.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - Start=1 at edge E0: latch Op, the sign flags, and |A|, |B| (magnitudes for signed ops, raw values for unsigned). Counter = 0; go to CALC.
  - Start=0: HiWe=1 writes WD to HI and LoWe=1 writes WD to LO at the edge (both may be set together).
  - Start and HiWe/LoWe in the same cycle: Start wins; the writes are dropped.
- CALC: one iteration per edge, E1..E_WIDTH.
  - Multiply: 2*WIDTH-bit accumulator, shift-add on the magnitudes.
  - Divide: restoring shift-subtract on the magnitudes.
  - Counter increments each edge; leave to FIX on the edge where counter = WIDTH-1.
- FIX, one edge (E_WIDTH+1):
  - Apply sign correction and write HI/LO.
  - MULT: negate the 2*WIDTH product if signA xor signB.
  - DIV: negate the quotient if signA xor signB; negate the remainder if signA.
  - Go to IDLE.
- Busy:
  - 1 in CALC and FIX; goes high after E0 and falls after E_WIDTH+1.
  - Busy is high for exactly WIDTH+1 cycles (33 at the default).
  - Busy is registered; it is not derived combinationally from Start.
- Done: 1 for exactly the one cycle after the FIX edge; 0 otherwise. MTHI/MTLO never raise Done.
- HI/LO hold their previous values throughout CALC; they update only at FIX, at reset, or on an MTHI/MTLO write in IDLE.
- While Busy:
  - Start is ignored; no queueing.
  - HiWe/LoWe are ignored.
  - A, B and Op may change freely without affecting the result.
- Back-to-back: Start asserted in the Done cycle is accepted (state is IDLE then).
- Divide by zero (B=0, DIVU or DIV): full latency, Done pulses, HI = A (original, unsigned/signed as given), LO = all ones.
- Signed overflow: DIV of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0 (falls out of the magnitude path; must not hang or trap).
- MULT of 0x80000000 by 0x80000000 gives HI=0x40000000, LO=0.
- No X propagation: Op is fully decoded and all registers are reset.

Test Plan:
- Reset=0 for 2 cycles, then 1 -> HI=LO=0, Busy=0, Done=0. Then HiWe=1, WD=0x12345678; next cycle LoWe=1, WD=0x9ABCDEF0 -> HI=0x12345678, LO=0x9ABCDEF0, Done stays 0.
- MULTU A=B=0xFFFFFFFF -> Busy high 33 cycles, Done pulses once at cycle 34, HI=0xFFFFFFFE, LO=0x00000001. MULT A=0xFFFFFFFD (-3), B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- Divides:
  - DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU A=100, B=7 -> LO=14, HI=2.
  - DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU A=0xDEADBEEF, B=0 -> Done after 33 busy cycles, HI=0xDEADBEEF, LO=0xFFFFFFFF.
- Busy-cycle interference and back-to-back:
  - Start MULTU 3*4; at busy cycle 10 pulse Start (DIVU 9/3) and HiWe with WD=0xAAAA -> both ignored; LO=12, HI=0.
  - New Start in the Done cycle -> accepted, Busy high next cycle.
- Start MULTU 6*7; drive Reset=0 at busy cycle 15 -> HI=LO=0, Busy=0 immediately. After release with no Start, Done never pulses.
